// File: rtl/lsu_param_pkg.sv
// lsu_param shared definitions
// core_state codes and lsu_state encodings
package lsu_pkg;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [2:0] {
    LSU_IDLE    = 3'd0,
    LSU_WAITING = 3'd1,
    LSU_DONE    = 3'd2,
    LSU_RETRY   = 3'd3,
    LSU_ERROR   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_param_if.sv
// lsu_param memory channel bundle
// master = LSU side, slave = memory controller side
interface lsu_param_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_param_timeout_counter.sv
// lsu_param per-attempt wait timer
// expired pulses while enabled at count TIMEOUT-1
module lsu_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
      localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);
      logic [TW-1:0] timer;

      // count while enabled, saturating at TIMEOUT
      always_ff @(posedge clk) begin
        if (reset || clear)
          timer <= '0;
        else if (enable && timer != SAT)
          timer <= timer + 1'b1;
      end

      assign expired = enable && (timer == LAST);
    end
  endgenerate
endmodule

// File: rtl/lsu_param.sv
// lsu_param: per-thread load/store unit
// latched op, per-attempt timeout, bounded re-issue
module lsu_param
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRIES = 2,
  localparam int RW = (MAX_RETRIES > 0) ?
                      $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_param_if.master          mem,
  output logic [2:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error,
  output logic [RW-1:0]        retry_count
);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);

  lsu_state_t           state_q, state_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rv_q, rv_d;
  logic                 wv_q, wv_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [RW-1:0]        rc_q, rc_d;
  logic                 rdy;
  logic                 expired;

  lsu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != LSU_WAITING),
    .enable  (state_q == LSU_WAITING),
    .expired (expired)
  );

  // only the channel of the latched op can complete it
  assign rdy = wr_q ? mem.mem_write_ready
                    : mem.mem_read_ready;

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rv_d    = rv_q;
    wv_d    = wv_q;
    out_d   = out_q;
    err_d   = err_q;
    rc_d    = rc_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (core_state == CORE_REQUEST) begin
          if (decoded_mem_read_enable &&
              decoded_mem_write_enable) begin
            err_d   = 1'b1;
            rc_d    = '0;
            state_d = LSU_ERROR;
          end else if (decoded_mem_read_enable ||
                       decoded_mem_write_enable) begin
            wr_d    = decoded_mem_write_enable;
            addr_d  = rs;
            data_d  = rt;
            rv_d    = decoded_mem_read_enable;
            wv_d    = decoded_mem_write_enable;
            rc_d    = '0;
            state_d = LSU_WAITING;
          end
        end
      end
      LSU_WAITING: begin
        if (rdy) begin
          rv_d = 1'b0;
          wv_d = 1'b0;
          if (!wr_q)
            out_d = mem.mem_read_data;
          state_d = LSU_DONE;
        end else if (expired) begin
          rv_d = 1'b0;
          wv_d = 1'b0;
          if (rc_q < MAXR) begin
            rc_d    = rc_q + 1'b1;
            state_d = LSU_RETRY;
          end else begin
            err_d   = 1'b1;
            state_d = LSU_ERROR;
          end
        end
      end
      LSU_RETRY: begin
        rv_d    = !wr_q;
        wv_d    = wr_q;
        state_d = LSU_WAITING;
      end
      LSU_DONE, LSU_ERROR: begin
        if (core_state == CORE_UPDATE) begin
          err_d   = 1'b0;
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rv_q    <= 1'b0;
      wv_q    <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rv_q    <= rv_d;
      wv_q    <= wv_d;
      out_q   <= out_d;
      err_q   <= err_d;
      rc_q    <= rc_d;
    end
  end

  assign mem.mem_read_valid    = rv_q;
  assign mem.mem_read_address  = addr_q;
  assign mem.mem_write_valid   = wv_q;
  assign mem.mem_write_address = addr_q;
  assign mem.mem_write_data    = data_q;
  assign lsu_state             = state_q;
  assign lsu_out               = out_q;
  assign lsu_error             = err_q;
  assign retry_count           = rc_q;
endmodule

// File: tb/tb_lsu_param.sv
// tb_lsu_param: directed scoreboard bench
// A: 8/8 T=4 R=2, B: 12/16 T=16 R=2
module tb_lsu_param;
  import lsu_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] data;
    logic [1:0]  rc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [2:0]  cs_a = '0, cs_b = '0;
  logic        rd_a = 0, wr_a = 0;
  logic        rd_b = 0, wr_b = 0;
  logic [7:0]  rs_a = '0, rt_a = '0;
  logic [11:0] rs_b = '0;
  logic [15:0] rt_b = '0;
  logic [2:0]  st_a, st_b;
  logic [7:0]  out_a;
  logic [15:0] out_b;
  logic        err_a, err_b;
  logic [1:0]  rc_a, rc_b;

  exp_t qa[$];
  exp_t qb[$];

  lsu_param_if #(.ADDR_BITS(8), .DATA_BITS(8)) ma();
  lsu_param_if #(.ADDR_BITS(12), .DATA_BITS(16)) mb();

  lsu_param #(
    .ADDR_BITS(8), .DATA_BITS(8),
    .TIMEOUT(4), .MAX_RETRIES(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .core_state(cs_a),
    .decoded_mem_read_enable(rd_a),
    .decoded_mem_write_enable(wr_a),
    .rs(rs_a), .rt(rt_a),
    .mem(ma.master),
    .lsu_state(st_a), .lsu_out(out_a),
    .lsu_error(err_a), .retry_count(rc_a)
  );

  lsu_param #(
    .ADDR_BITS(12), .DATA_BITS(16),
    .TIMEOUT(16), .MAX_RETRIES(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .core_state(cs_b),
    .decoded_mem_read_enable(rd_b),
    .decoded_mem_write_enable(wr_b),
    .rs(rs_b), .rt(rt_b),
    .mem(mb.master),
    .lsu_state(st_b), .lsu_out(out_b),
    .lsu_error(err_b), .retry_count(rc_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st,
                              input logic [15:0] d,
                              input logic [1:0] rc,
                              input logic e);
    exp_t x;
    x.st = st; x.data = d; x.rc = rc; x.err = e;
    return x;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor A: compare on each entry into DONE/ERROR
  initial begin : mon_a
    logic [2:0] pa;
    exp_t e;
    pa = 3'd0;
    forever begin
      @(negedge clk);
      if ((st_a == LSU_DONE || st_a == LSU_ERROR) &&
          pa != LSU_DONE && pa != LSU_ERROR) begin
        if (qa.size() == 0) begin
          check("a_unexpected_end", 32'(st_a), 32'hFF);
        end else begin
          e = qa.pop_front();
          check("a_sb_state", 32'(st_a), 32'(e.st));
          check("a_sb_out", 32'(out_a), 32'(e.data));
          check("a_sb_retry", 32'(rc_a), 32'(e.rc));
          check("a_sb_err", 32'(err_a), 32'(e.err));
          check("a_sb_valids",
                {ma.mem_read_valid, ma.mem_write_valid}, 0);
        end
      end
      pa = st_a;
    end
  end

  // monitor B: store completions compare write data
  initial begin : mon_b
    logic [2:0] pb;
    exp_t e;
    pb = 3'd0;
    forever begin
      @(negedge clk);
      if ((st_b == LSU_DONE || st_b == LSU_ERROR) &&
          pb != LSU_DONE && pb != LSU_ERROR) begin
        if (qb.size() == 0) begin
          check("b_unexpected_end", 32'(st_b), 32'hFF);
        end else begin
          e = qb.pop_front();
          check("b_sb_state", 32'(st_b), 32'(e.st));
          check("b_sb_wdata", 32'(mb.mem_write_data),
                32'(e.data));
          check("b_sb_retry", 32'(rc_b), 32'(e.rc));
          check("b_sb_err", 32'(err_b), 32'(e.err));
        end
      end
      pb = st_b;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [11:0] pat12;
    logic [8:0]  pat9;
    int hi;
    logic v;
    ma.mem_read_ready = 0; ma.mem_read_data = '0;
    ma.mem_write_ready = 0;
    mb.mem_read_ready = 0; mb.mem_read_data = '0;
    mb.mem_write_ready = 0;

    tick(2);
    check("rst_state_a", 32'(st_a), 0);
    check("rst_out_a", 32'(out_a), 0);
    check("rst_err_a", 32'(err_a), 0);
    check("rst_rc_a", 32'(rc_a), 0);
    check("rst_valid_a",
          {ma.mem_read_valid, ma.mem_write_valid}, 0);
    check("rst_state_b", 32'(st_b), 0);
    check("rst_wvalid_b", 32'(mb.mem_write_valid), 0);
    reset = 0;
    tick();

    // load, ready on third valid cycle
    qa.push_back(mk(LSU_DONE, 16'h00A5, 2'd0, 1'b0));
    rs_a = 8'h12; rd_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0; rs_a = 8'hFF;
    check("ld_addr", 32'(ma.mem_read_address), 32'h12);
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      ma.mem_read_ready = (i == 2);
      ma.mem_read_data  = (i == 2) ? 8'hA5 : 8'h00;
      if (ma.mem_read_valid) hi++;
      tick();
    end
    ma.mem_read_ready = 0; ma.mem_read_data = '0;
    check("ld_valid_cycles", 32'(hi), 3);
    check("ld_valid_drop", 32'(ma.mem_read_valid), 0);
    check("ld_out", 32'(out_a), 32'hA5);
    cs_a = CORE_UPDATE;
    tick();
    cs_a = 3'd0;
    check("ld_update_idle", 32'(st_a), 32'(LSU_IDLE));

    // zero-wait load: DONE two edges after REQUEST
    qa.push_back(mk(LSU_DONE, 16'h003C, 2'd0, 1'b0));
    rs_a = 8'h21; rd_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0;
    ma.mem_read_ready = 1; ma.mem_read_data = 8'h3C;
    tick();
    ma.mem_read_ready = 0; ma.mem_read_data = '0;
    check("zw_done", 32'(st_a), 32'(LSU_DONE));
    cs_a = CORE_UPDATE; tick(); cs_a = 3'd0;

    // two timeouts, ready in third attempt;
    // write_ready in first attempt must be ignored
    qa.push_back(mk(LSU_DONE, 16'h005A, 2'd2, 1'b0));
    rs_a = 8'h34; rd_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0;
    for (int i = 0; i < 12; i++) begin
      ma.mem_read_ready  = (i == 11);
      ma.mem_read_data   = 8'h5A;
      ma.mem_write_ready = (i < 4);
      pat12[i] = ma.mem_read_valid;
      tick();
    end
    ma.mem_read_ready = 0; ma.mem_write_ready = 0;
    check("retry_pattern", 32'(pat12), 32'hDEF);
    check("retry_addr", 32'(ma.mem_read_address), 32'h34);
    cs_a = CORE_UPDATE; tick(); cs_a = 3'd0;

    // ready coincides with expiry of second attempt
    qa.push_back(mk(LSU_DONE, 16'h00C3, 2'd1, 1'b0));
    rs_a = 8'h40; rd_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0;
    for (int i = 0; i < 9; i++) begin
      ma.mem_read_ready = (i == 8);
      ma.mem_read_data  = 8'hC3;
      pat9[i] = ma.mem_read_valid;
      tick();
    end
    ma.mem_read_ready = 0;
    check("coin_pattern", 32'(pat9), 32'h1EF);
    cs_a = CORE_UPDATE; tick(); cs_a = 3'd0;

    // exhaustion: ERROR 14 cycles after issue
    qa.push_back(mk(LSU_ERROR, 16'h00C3, 2'd2, 1'b1));
    rs_a = 8'h55; rd_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0;
    tick(13);
    check("exh_pre", 32'(st_a), 32'(LSU_WAITING));
    tick();
    check("exh_state", 32'(st_a), 32'(LSU_ERROR));
    tick(2);
    check("exh_hold", 32'(st_a), 32'(LSU_ERROR));
    check("exh_hold_err", 32'(err_a), 1);
    cs_a = CORE_UPDATE; tick(); cs_a = 3'd0;
    check("exh_idle", 32'(st_a), 32'(LSU_IDLE));
    check("exh_err_clr", 32'(err_a), 0);

    // both enables: no request, ERROR next cycle
    qa.push_back(mk(LSU_ERROR, 16'h00C3, 2'd0, 1'b1));
    rd_a = 1; wr_a = 1; cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; rd_a = 0; wr_a = 0;
    v = 0;
    for (int i = 0; i < 3; i++) begin
      v |= ma.mem_read_valid | ma.mem_write_valid;
      tick();
    end
    check("both_no_valid", 32'(v), 0);
    cs_a = CORE_UPDATE; tick(); cs_a = 3'd0;

    // reset while waiting on a store
    rs_a = 8'h77; rt_a = 8'h99; wr_a = 1;
    cs_a = CORE_REQUEST;
    tick();
    cs_a = 3'd0; wr_a = 0;
    check("rw_wdata", 32'(ma.mem_write_data), 32'h99);
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("rw_state", 32'(st_a), 32'(LSU_IDLE));
    check("rw_outs",
          {ma.mem_write_valid, ma.mem_read_valid, err_a,
           rc_a, out_a, ma.mem_write_address,
           ma.mem_write_data}, 0);
    tick();

    // wide store, operands change after issue
    qb.push_back(mk(LSU_DONE, 16'hBEEF, 2'd0, 1'b0));
    rs_b = 12'hABC; rt_b = 16'hBEEF; wr_b = 1;
    cs_b = CORE_REQUEST;
    tick();
    cs_b = 3'd0; wr_b = 0; rs_b = '0; rt_b = '0;
    for (int i = 0; i < 4; i++) begin
      mb.mem_read_ready  = 1;
      mb.mem_write_ready = (i == 3);
      check("st_hold",
            {mb.mem_write_valid, 3'b0,
             mb.mem_write_address, mb.mem_write_data},
            {1'b1, 3'b0, 12'hABC, 16'hBEEF});
      tick();
    end
    mb.mem_read_ready = 0; mb.mem_write_ready = 0;
    check("st_drop", 32'(mb.mem_write_valid), 0);
    cs_b = CORE_UPDATE; tick(); cs_b = 3'd0;
    check("st_idle", 32'(st_b), 32'(LSU_IDLE));

    tick(2);
    check("sb_a_drained", 32'(qa.size()), 0);
    check("sb_b_drained", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_param.md
# lsu_param

Parametrised load/store unit, one per thread in each core, between the core's decoded-instruction and register-file outputs and the memory controller's per-thread read/write channels. It generalises the existing LSU in address and data width. It latches the operation at issue and adds a per-request timeout with bounded re-issue. It reports an error state for timed-out requests and for illegal simultaneous read+write decodes.

## Interface
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- TIMEOUT, 16, cycles a request may wait for ready before withdrawal; 0 disables timeout
- MAX_RETRIES, 2, re-issues after timeout before ERROR
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_state  in  3  core pipeline state (REQUEST=3'b011, UPDATE=3'b110)
- decoded_mem_read_enable  in  1  current instruction is a load
- decoded_mem_write_enable  in  1  current instruction is a store
- rs  in  ADDR_BITS  address operand
- rt  in  DATA_BITS  store data operand
- mem_read_valid  out  1  read request
- mem_read_address  out  ADDR_BITS  read address
- mem_read_ready  in  1  read complete, data valid
- mem_read_data  in  DATA_BITS  read data
- mem_write_valid  out  1  write request
- mem_write_address  out  ADDR_BITS  write address
- mem_write_data  out  DATA_BITS  write data
- mem_write_ready  in  1  write accepted
- lsu_state  out  3  IDLE=0, WAITING=1, DONE=2, RETRY=3, ERROR=4
- lsu_out  out  DATA_BITS  last loaded data
- lsu_error  out  1  high while in ERROR
- retry_count  out  $clog2(MAX_RETRIES+1)  re-issues used by current request

## Operation
- Reset: all outputs 0, lsu_state IDLE. Reset mid-request withdraws valid on the next edge and discards the request.
- IDLE: act only when core_state==REQUEST.
  - Exactly one enable set: latch op, rs, rt; assert matching valid with latched address/data; clear timer and retry_count; go to WAITING.
  - Both enables set: issue nothing, set lsu_error, go to ERROR.
  - Neither set: stay in IDLE.
- Once latched, the operation runs to completion regardless of later enable, rs or rt changes.
- WAITING:
  - Matching ready high: drop valid. For a load, also capture data into lsu_out. Go to DONE.
  - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1: drop valid. If retry_count<MAX_RETRIES, increment retry_count and go to RETRY; else set lsu_error and go to ERROR.
  - Otherwise increment timer.
  - Ready is ignored for the operation not in flight.
- RETRY: exactly one cycle with valid low and ready ignored. Then re-assert valid with the latched address/data, clear the timer, and go to WAITING.
- DONE / ERROR: hold outputs. On core_state==UPDATE go to IDLE and clear lsu_error. lsu_out is unchanged on error.
- Timer width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- valid rises on the edge after REQUEST is sampled in IDLE.
- valid falls on the edge after ready is sampled; lsu_out updates on that same edge. lsu_state reads DONE one cycle after ready.
- Ready sampled in the same cycle that the timeout would fire: ready wins, go to DONE.
- Per attempt, valid is high for exactly TIMEOUT cycles, followed by 1 low cycle in RETRY.
- Worst case from issue to ERROR: (MAX_RETRIES+1)*TIMEOUT + MAX_RETRIES cycles.
- Zero-wait memory (ready in the first WAITING cycle): 2 cycles from REQUEST to DONE.

## Structure
- Package lsu_pkg holds:
  - the core_state constants CORE_REQUEST and CORE_UPDATE;
  - the lsu_state encodings (localparams or enum).
- Sub-module lsu_timeout_counter (params TIMEOUT), with:
  - inputs: clear, enable;
  - output: expired, a single-cycle pulse at TIMEOUT-1;
  - TIMEOUT=0 ties expired low.
- Read and write share one FSM; only the valid/ready pair selected by the latched op differs.

## Test plan
- Load, ADDR_BITS=DATA_BITS=8: rs=0x12, REQUEST, memory ready after 3 cycles with data 0xA5 -> mem_read_address=0x12; valid high 3 cycles; lsu_out=0xA5; DONE; UPDATE -> IDLE.
- Store, ADDR_BITS=12, DATA_BITS=16: rs=0xABC, rt=0xBEEF; rt changed to 0 after issue -> write address/data stay 0xABC/0xBEEF until ready; DONE.
- Timeout retry, TIMEOUT=4, MAX_RETRIES=2: ready given only during the third attempt -> valid pattern 4 high, 1 low, 4 high, 1 low, then high until ready; retry_count=2; DONE.
- Timeout exhaustion, same params, ready never -> ERROR after 14 cycles; lsu_error=1; valid 0; UPDATE clears lsu_error and returns to IDLE.
- Both enables set at REQUEST -> no valid ever asserted; ERROR next cycle; lsu_error=1.
- Reset asserted in WAITING, and ready coinciding with timer==TIMEOUT-1:
  - reset case -> next cycle all outputs 0, IDLE;
  - coinciding case -> DONE, retry_count unchanged.
